// File: rtl/space_inv_pkg.sv
// space_inv_pkg: shared types and constants for the alien fire scheduler
package space_inv_pkg;
  typedef enum logic [2:0] {IDLE, COUNT, FIRE, WAIT_LAUNCH, COOLDOWN} fire_state_t;
  localparam int NUM_ALIEN_ROCKETS = 3;
  localparam logic [6:0] RAGE_THRESHOLD = 7'd8;
  localparam logic [7:0] LEVEL_INTERVAL [0:3] = '{8'd60, 8'd45, 8'd30, 8'd20};
  function automatic logic [1:0] popcount3(input logic [NUM_ALIEN_ROCKETS-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction
endpackage

// File: rtl/fire_lfsr8.sv
// fire_lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4) with seed and advance enable
module fire_lfsr8 #(
  parameter logic [7:0] SEED     = 8'hA5,
  parameter int          OUT_BITS = 8
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                en_i,
  output logic [OUT_BITS-1:0] q_o
);
  logic [7:0] lfsr_q;
  // shift left, feedback from taps 8,6,5,4 into bit 0
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) lfsr_q <= SEED;
    else if (en_i) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign q_o = lfsr_q[OUT_BITS-1:0];
endmodule

// File: rtl/alien_fire_scheduler.sv
// alien_fire_scheduler: paces alien shots in frames; optional ALIEN_RAGE_EN halves the interval when few aliens remain
module alien_fire_scheduler
  import space_inv_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED       = 8'hA5,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd90,
  parameter int         LAUNCH_TIMEOUT  = 1023,
  parameter int         JITTER_BITS     = 4
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         isGameMode,
  input  logic [1:0]                   level,
  input  logic [6:0]                   aliensAlive,
  input  logic [NUM_ALIEN_ROCKETS-1:0] isActiveAliens,
  input  logic                         playerHit,
  output logic                         shootPulse,
  output logic [7:0]                   framesToShot,
  output logic [15:0]                  fireCount
);
  localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);
  fire_state_t      state_q;
  logic [7:0]       fts_q;
  logic             shoot_q;
  logic [15:0]      cnt_q;
  logic [1:0]       snap_q;
  logic [TW-1:0]    tmo_q;
  logic [JITTER_BITS-1:0] jitter;
  logic [7:0]       base_d;
  logic [7:0]       reload_d;
  logic [1:0]       busy_d;
  logic             can_fire_d;
  fire_lfsr8 #(.SEED(LFSR_SEED), .OUT_BITS(JITTER_BITS)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .en_i   (startOfFrame),
    .q_o    (jitter)
  );
`ifdef ALIEN_RAGE_EN
  assign base_d = (aliensAlive != '0 && aliensAlive <= RAGE_THRESHOLD) ? LEVEL_INTERVAL[level] >> 1 : LEVEL_INTERVAL[level];
`else
  assign base_d = LEVEL_INTERVAL[level];
`endif
  assign reload_d   = base_d + 8'(jitter);
  assign busy_d     = popcount3(isActiveAliens);
  assign can_fire_d = aliensAlive != '0 && isActiveAliens != '1;
  // game-mode gate, then player hit, then per-state pacing; all outputs registered
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      fts_q   <= '0;
      shoot_q <= 1'b0;
      cnt_q   <= '0;
      snap_q  <= '0;
      tmo_q   <= '0;
    end else begin
      shoot_q <= 1'b0;
      if (!isGameMode) begin
        state_q <= IDLE;
        fts_q   <= '0;
      end else if (playerHit && state_q != IDLE) begin
        state_q <= COOLDOWN;
        fts_q   <= COOLDOWN_FRAMES;
      end else begin
        case (state_q)
          IDLE: begin
            fts_q   <= reload_d;
            state_q <= COUNT;
          end
          COUNT:
            if (fts_q == '0 && can_fire_d) begin
              state_q <= FIRE;
              shoot_q <= 1'b1;
            end else if (startOfFrame && fts_q != '0) fts_q <= fts_q - 8'd1;
          FIRE: begin
            snap_q  <= busy_d;
            tmo_q   <= '0;
            state_q <= WAIT_LAUNCH;
          end
          WAIT_LAUNCH:
            if (busy_d > snap_q) begin
              cnt_q   <= cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
              fts_q   <= reload_d;
              state_q <= COUNT;
            end else if (tmo_q == TW'(LAUNCH_TIMEOUT - 1)) begin
              fts_q   <= reload_d;
              state_q <= COUNT;
            end else tmo_q <= tmo_q + 1'b1;
          COOLDOWN:
            if (fts_q == '0) begin
              fts_q   <= reload_d;
              state_q <= COUNT;
            end else if (startOfFrame) fts_q <= fts_q - 8'd1;
          default: state_q <= IDLE;
        endcase
      end
    end
  assign shootPulse   = shoot_q;
  assign framesToShot = fts_q;
  assign fireCount    = cnt_q;
endmodule

// File: doc/alien_fire_scheduler.md
Name: alien_fire_scheduler

Overview:
- Decides when the alien formation fires.
- Emits the one-clock shootPulse consumed by rocketsController, paced in frames by difficulty level plus LFSR jitter.
- Fires only when an alien rocket slot is free, then waits for the launch to be acknowledged.
- Sits between the frame/game-state logic and rocketsController.

Parameters:
- LFSR_SEED, 8'hA5, non-zero reset value of the 8-bit jitter LFSR.
- COOLDOWN_FRAMES, 90, frames of silence after the player is hit.
- LAUNCH_TIMEOUT, 1023, clocks to wait for a launch before giving up.
- JITTER_BITS, 4, number of LFSR bits added to the interval (0..15 frames).

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- startOfFrame  in  1  one-clock pulse per frame
- isGameMode  in  1  high while gameplay runs
- level  in  2  difficulty 0..3
- aliensAlive  in  7  number of live aliens, 0..84
- isActiveAliens  in  3  active flags of the alien rocket slots
- playerHit  in  1  one-clock pulse, player struck
- shootPulse  out  1  one-clock fire request to rocketsController
- framesToShot  out  8  current countdown value, for debug/HUD
- fireCount  out  16  shots launched since reset, saturating

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE; shootPulse=0; framesToShot=0; fireCount=0; LFSR=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances once per startOfFrame regardless of state.
- Base interval by level: 0→60, 1→45, 2→30, 3→20 frames.
- reload = base + LFSR[JITTER_BITS-1:0], 8-bit, no overflow possible (max 75).
- IDLE:
  - Outputs quiet.
  - isGameMode=1 → load framesToShot=reload, go COUNT.
- COUNT:
  - On startOfFrame, framesToShot decrements if non-zero.
  - When framesToShot==0, aliensAlive!=0 and isActiveAliens!=3'b111 → go FIRE.
  - If all three slots are busy or no aliens are alive, stay in COUNT at 0. Fire on the first clock the condition clears.
- FIRE:
  - shootPulse=1 for exactly one clock.
  - Snapshot popcount(isActiveAliens).
  - Go WAIT_LAUNCH.
- WAIT_LAUNCH:
  - A popcount greater than the snapshot is the launch ack.
  - On ack: fireCount+1 (saturates at 16'hFFFF), reload framesToShot, go COUNT.
  - A clock counter reaching LAUNCH_TIMEOUT also reloads and goes COUNT, with no fireCount increment. This covers rocketsController still scanning or an empty column.
- COOLDOWN:
  - Entered from COUNT, FIRE or WAIT_LAUNCH on playerHit.
  - framesToShot=COOLDOWN_FRAMES, decremented per startOfFrame.
  - At 0 → reload, go COUNT.
  - A playerHit during COOLDOWN restarts it.
- Priority, highest first: isGameMode=0 (→IDLE from any state, framesToShot=0, next cycle) > playerHit > state logic.
- A playerHit in the same clock as FIRE still emits that pulse. Cooldown starts the next clock.
- A startOfFrame coinciding with a COUNT→FIRE transition is consumed by the LFSR only.
- Latency: framesToShot==0 with a free slot → shootPulse on the next clock.
- Never more than one outstanding shootPulse.

Optional Feature:
- Macro ALIEN_RAGE_EN.
- When defined: if aliensAlive<=8 and !=0, the reload base is halved (right shift by 1) before jitter is added. For example, level 3 with 5 aliens gives base 10.
- When undefined: base depends only on level. Logic and compare are absent.

Decomposition:
- Package space_inv_pkg:
  - typedef enum fire_state_t {IDLE, COUNT, FIRE, WAIT_LAUNCH, COOLDOWN}
  - constant LEVEL_INTERVAL[0:3]
  - constant NUM_ALIEN_ROCKETS=3
  - constant RAGE_THRESHOLD=8
- One sub-module, fire_lfsr8: 8-bit LFSR with seed and advance enable. Also reused for randCol/randSpeed.

Test Plan:
- Reset with isGameMode=1, level=0, seed A5 → framesToShot=60+(A5&F)=65. shootPulse on the clock after the 65th following startOfFrame.
- isActiveAliens=3'b111 at countdown 0 → no pulse. Clear bit 1 → pulse on the next clock. Set bit 1 two clocks later → fireCount=1.
- After FIRE, hold isActiveAliens unchanged → return to COUNT after 1023 clocks, fireCount unchanged.
- playerHit during COUNT at framesToShot=10 → framesToShot=90. No shootPulse for 90 frames.
- isGameMode dropped during WAIT_LAUNCH → IDLE next clock, framesToShot=0, no further pulses.
- ALIEN_RAGE_EN defined, level=3, aliensAlive=5, LFSR low nibble 0 → reload=10. With aliensAlive=9 → 20.
